// File: rtl/phy_stub_pkg.sv
// Shared types and constants for the PHY clock-generator stub.
package phy_stub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } ch_state_e;

  localparam int DIV_DEFAULT = 1;
  localparam int N_CH_MAX    = 8;

  // A single channel still needs one select bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phy_clkgen_stub_if.sv
// Configuration port of the clock-generator stub: one valid/ready write channel.
interface phy_clkgen_stub_if #(
  parameter int N_CH  = 2,
  parameter int DIV_W = 8
);
  import phy_stub_pkg::*;

  localparam int CH_W = ch_width(N_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_en;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_en,
    output cfg_ready
  );

endinterface

// File: rtl/phy_stub_clkdiv.sv
// One divided-clock channel: half-period counter, IDLE/RUN/PEND FSM and a
// pending update that only takes effect on the falling edge of clk_o.
module phy_stub_clkdiv
  import phy_stub_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             en_i,
  output logic             clk_o,
  output logic             locked_o,
  output logic             pend_o
);

  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pdiv_q, pdiv_d;
  logic             pen_q, pen_d;
  logic             out_q, out_d;

  logic [DIV_W-1:0] div_in;
  logic             terminal;
  logic             boundary;

  assign div_in   = (div_i == '0) ? DIV_W'(1) : div_i;
  assign terminal = (cnt_q == div_q - DIV_W'(1));
  // Only a 1->0 toggle may end a period, so updates never cut a high phase.
  assign boundary = terminal && out_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pdiv_d  = pdiv_q;
    pen_d   = pen_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (we_i) begin
          div_d = div_in;
          if (en_i) begin
            state_d = RUN;
            cnt_d   = '0;
            out_d   = 1'b0;
          end
        end
      end
      RUN: begin
        if (terminal) begin
          cnt_d = '0;
          out_d = ~out_q;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
        if (we_i) begin
          state_d = PEND;
          pdiv_d  = div_in;
          pen_d   = en_i;
        end
      end
      PEND: begin
        if (terminal) begin
          cnt_d = '0;
          out_d = ~out_q;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
        if (boundary) begin
          div_d   = pdiv_q;
          state_d = pen_q ? RUN : IDLE;
          pdiv_d  = DIV_W'(DIV_DEFAULT);
          pen_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_W'(DIV_DEFAULT);
      pdiv_q  <= DIV_W'(DIV_DEFAULT);
      pen_q   <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pdiv_q  <= pdiv_d;
      pen_q   <= pen_d;
      out_q   <= out_d;
    end
  end

  assign clk_o    = out_q;
  assign locked_o = (state_q == RUN);
  assign pend_o   = (state_q == PEND);

endmodule

// File: rtl/phy_clkgen_stub.sv
// Behavioural PHY clock generator: N_CH divided clocks plus an optional
// periodic trigger, built only when PHY_STUB_TRIG_EN is defined.
module phy_clkgen_stub
  import phy_stub_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int DIV_W  = 8,
  parameter int TRIG_W = 16
) (
  input  logic              clk,
  input  logic              ext_rstb,
  phy_clkgen_stub_if.slave  cfg,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   locked,
  input  logic [TRIG_W-1:0] trig_period,
  output logic              trig_pulse
);

  localparam int CH_W = ch_width(N_CH);

  logic [N_CH-1:0] pend;
  logic            ready;

  // Back-pressure only the channel holding an unapplied update; other
  // channels and out-of-range selects are always accepted.
  always_comb begin
    ready = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i) && pend[i]) begin
        ready = 1'b0;
      end
    end
  end

  assign cfg.cfg_ready = ready;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic we;

    assign we = cfg.cfg_valid && ready && (cfg.cfg_ch == CH_W'(gi));

    phy_stub_clkdiv #(
      .DIV_W (DIV_W)
    ) u_div (
      .clk      (clk),
      .rst_n    (ext_rstb),
      .we_i     (we),
      .div_i    (cfg.cfg_div),
      .en_i     (cfg.cfg_en),
      .clk_o    (clk_out[gi]),
      .locked_o (locked[gi]),
      .pend_o   (pend[gi])
    );
  end

`ifdef PHY_STUB_TRIG_EN
  logic [TRIG_W-1:0] tcnt_q, tcnt_d;
  logic              pulse_q, pulse_d;

  // Compare with >= so lowering the period below the running count fires next cycle.
  always_comb begin
    tcnt_d  = tcnt_q + TRIG_W'(1);
    pulse_d = 1'b0;
    if (trig_period == '0) begin
      tcnt_d = '0;
    end else if (tcnt_q >= trig_period - TRIG_W'(1)) begin
      tcnt_d  = '0;
      pulse_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge ext_rstb) begin
    if (!ext_rstb) begin
      tcnt_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign trig_pulse = pulse_q;
`else
  logic unused_trig;

  assign unused_trig = ^trig_period;
  assign trig_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_phy_clkgen_stub.sv
// Scoreboard bench for phy_clkgen_stub: stimulus queues time-stamped expected
// output bits, a negedge monitor pops and compares them.
module tb_phy_clkgen_stub;

  // Three channels give a two-bit select, so cfg_ch=3 is a real out-of-range address.
  localparam int N_CH   = 3;
  localparam int DIV_W  = 8;
  localparam int TRIG_W = 16;
  localparam int CH_W   = 2;

  localparam int SEL_CLK = 0;
  localparam int SEL_LCK = 8;
  localparam int SEL_RDY = 16;
  localparam int SEL_TRG = 17;

`ifdef PHY_STUB_TRIG_EN
  localparam bit TRIG_ON = 1'b1;
`else
  localparam bit TRIG_ON = 1'b0;
`endif

  typedef struct {
    string name;
    int    cyc;
    int    sel;
    logic  v;
  } exp_t;

  logic              clk = 1'b0;
  logic              ext_rstb = 1'b0;
  logic [N_CH-1:0]   clk_out;
  logic [N_CH-1:0]   locked;
  logic [TRIG_W-1:0] trig_period = '0;
  logic              trig_pulse;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  phy_clkgen_stub_if #(.N_CH(N_CH), .DIV_W(DIV_W)) cfg_if ();

  phy_clkgen_stub #(
    .N_CH   (N_CH),
    .DIV_W  (DIV_W),
    .TRIG_W (TRIG_W)
  ) dut (
    .clk         (clk),
    .ext_rstb    (ext_rstb),
    .cfg         (cfg_if),
    .clk_out     (clk_out),
    .locked      (locked),
    .trig_period (trig_period),
    .trig_pulse  (trig_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic actual(input int sel);
    if (sel >= SEL_CLK && sel < SEL_CLK + N_CH) return clk_out[sel - SEL_CLK];
    if (sel >= SEL_LCK && sel < SEL_LCK + N_CH) return locked[sel - SEL_LCK];
    if (sel == SEL_RDY) return cfg_if.cfg_ready;
    return trig_pulse;
  endfunction

  task automatic expect_at(input string name, input int delta, input int sel, input logic v);
    exp_t e;
    int   idx;
    e.name = name;
    e.cyc  = cyc + delta;
    e.sel  = sel;
    e.v    = v;
    idx    = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > e.cyc) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: check for cycle %0d not reached (now %0d)", e.name, e.cyc, cyc);
      end else if (actual(e.sel) !== e.v) begin
        n_bad++;
        $display("FAIL %s @cycle %0d: got %b, expected %b", e.name, cyc, actual(e.sel), e.v);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns 1 unit after the accept edge.
  task automatic cfg_write(input int ch, input int div, input logic en);
    int waited;
    waited = 0;
    cfg_if.cfg_ch    = CH_W'(ch);
    cfg_if.cfg_div   = DIV_W'(div);
    cfg_if.cfg_en    = en;
    cfg_if.cfg_valid = 1'b1;
    #1;
    while (!cfg_if.cfg_ready && waited < 64) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (!cfg_if.cfg_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cfg_timeout: ready=%b after %0d cycles, expected 1", cfg_if.cfg_ready, waited);
    end
    @(posedge clk);
    #1;
    cfg_if.cfg_valid = 1'b0;
    $display("cfg ch=%0d div=%0d en=%0b accepted at cycle %0d", ch, div, en, cyc);
  endtask

  task automatic expect_idle_outputs(input string name, input int delta);
    for (int i = 0; i < N_CH; i++) begin
      expect_at(name, delta, SEL_CLK + i, 1'b0);
      expect_at(name, delta, SEL_LCK + i, 1'b0);
    end
    expect_at(name, delta, SEL_RDY, 1'b1);
    expect_at(name, delta, SEL_TRG, 1'b0);
  endtask

  initial begin
    int a_cyc, b_cyc, c_cyc, e_cyc, f_cyc;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_en    = 1'b0;

    // Reset state
    for (int d = 1; d <= 3; d++) expect_idle_outputs("reset", d);
    wait_cycles(3);
    ext_rstb = 1'b1;
    $display("reset released at cycle %0d", cyc);
    wait_cycles(1);

    // ch0 D=3: locked next edge, first rise 3 cycles after accept, period 6
    cfg_write(0, 3, 1'b1);
    a_cyc = cyc;
    expect_at("t1_lock0", 0, SEL_LCK + 0, 1'b1);
    expect_at("t1_rdy", 0, SEL_RDY, 1'b1);
    for (int k = 0; k <= 12; k++) begin
      expect_at("t1_clk0", k, SEL_CLK + 0, logic'((k / 3) % 2));
    end
    for (int k = 0; k <= 12; k += 4) begin
      expect_at("t1_clk1", k, SEL_CLK + 1, 1'b0);
      expect_at("t1_lock1", k, SEL_LCK + 1, 1'b0);
    end
    wait_cycles(15);

    // Reprogram ch0 to D=5 during a high phase: held until the falling edge
    cfg_write(0, 5, 1'b1);
    b_cyc = cyc;
    expect_at("t2_rdy_pend", 0, SEL_RDY, 1'b0);
    expect_at("t2_rdy_pend", 1, SEL_RDY, 1'b0);
    expect_at("t2_rdy_back", 2, SEL_RDY, 1'b1);
    expect_at("t2_lock_pend", 0, SEL_LCK + 0, 1'b0);
    expect_at("t2_lock_pend", 1, SEL_LCK + 0, 1'b0);
    expect_at("t2_lock_back", 2, SEL_LCK + 0, 1'b1);
    expect_at("t2_clk0_old", 0, SEL_CLK + 0, 1'b1);
    expect_at("t2_clk0_old", 1, SEL_CLK + 0, 1'b1);
    for (int j = 2; j <= 17; j++) begin
      expect_at("t2_clk0_new", j, SEL_CLK + 0, logic'(((j - 2) / 5) % 2));
    end
    wait_cycles(18);

    // Disable ch0 mid-high: finishes the period then parks low
    cfg_write(0, 5, 1'b0);
    c_cyc = cyc;
    for (int d = 0; d <= 2; d++) expect_at("t3_clk0_finish", d, SEL_CLK + 0, 1'b1);
    for (int d = 3; d <= 8; d++) expect_at("t3_clk0_park", d, SEL_CLK + 0, 1'b0);
    for (int d = 0; d <= 8; d++) expect_at("t3_lock0", d, SEL_LCK + 0, 1'b0);
    expect_at("t3_rdy_pend", 0, SEL_RDY, 1'b0);
    expect_at("t3_rdy_idle", 3, SEL_RDY, 1'b1);
    wait_cycles(9);

    // cfg_div=0 on ch1 behaves as D=1
    cfg_write(1, 0, 1'b1);
    e_cyc = cyc;
    expect_at("t4_lock1", 0, SEL_LCK + 1, 1'b1);
    for (int k = 0; k <= 7; k++) begin
      expect_at("t4_clk1_d1", k, SEL_CLK + 1, logic'(k % 2));
      expect_at("t4_clk0_idle", k, SEL_CLK + 0, 1'b0);
    end

    // Out-of-range select: accepted, no channel changes
    expect_at("t4_rdy_oor", 0, SEL_RDY, 1'b1);
    cfg_write(3, 7, 1'b1);
    for (int j = 0; j <= 5; j++) begin
      expect_at("t4_clk1_keep", j, SEL_CLK + 1, logic'((cyc - e_cyc + j) % 2));
      expect_at("t4_lock1_keep", j, SEL_LCK + 1, 1'b1);
      expect_at("t4_clk2", j, SEL_CLK + 2, 1'b0);
      expect_at("t4_lock2", j, SEL_LCK + 2, 1'b0);
      expect_at("t4_lock0", j, SEL_LCK + 0, 1'b0);
    end
    wait_cycles(6);

    // Trigger period 4, then off
    trig_period = 16'd4;
    $display("trig_period=4 at cycle %0d", cyc);
    for (int k = 1; k <= 12; k++) begin
      expect_at("t5_trig4", k, SEL_TRG, TRIG_ON && (k % 4 == 0));
    end
    wait_cycles(12);
    trig_period = 16'd0;
    $display("trig_period=0 at cycle %0d", cyc);
    for (int k = 1; k <= 8; k++) expect_at("t5_trig_off", k, SEL_TRG, 1'b0);
    wait_cycles(8);

    // Lowering the period below the running count fires on the next cycle
    trig_period = 16'd8;
    $display("trig_period=8 at cycle %0d", cyc);
    for (int k = 1; k <= 5; k++) expect_at("t5_trig8", k, SEL_TRG, 1'b0);
    wait_cycles(5);
    trig_period = 16'd2;
    $display("trig_period=2 at cycle %0d", cyc);
    expect_at("t5_trig_low", 1, SEL_TRG, TRIG_ON);
    expect_at("t5_trig_low", 2, SEL_TRG, 1'b0);
    expect_at("t5_trig_low", 3, SEL_TRG, TRIG_ON);
    wait_cycles(3);
    trig_period = 16'd0;

    // Asynchronous reset while ch0 and ch1 both run
    cfg_write(0, 2, 1'b1);
    f_cyc = cyc;
    expect_at("t6_lock0", 0, SEL_LCK + 0, 1'b1);
    expect_at("t6_lock1", 0, SEL_LCK + 1, 1'b1);
    expect_at("t6_clk0_pre", 2, SEL_CLK + 0, 1'b1);
    wait_cycles(3);
    ext_rstb = 1'b0;
    $display("reset asserted at cycle %0d (ch0 started at %0d)", cyc, f_cyc);
    expect_idle_outputs("t6_rst_async", 0);
    wait_cycles(2);
    expect_idle_outputs("t6_rst_hold", 0);
    ext_rstb = 1'b1;
    $display("reset released at cycle %0d", cyc);
    for (int d = 1; d <= 4; d++) expect_idle_outputs("t6_post_rst", d);
    wait_cycles(5);

    begin
      int guard;
      guard = 0;
      while (sb.size() > 0 && guard < 100) begin
        wait_cycles(1);
        guard++;
      end
      if (sb.size() > 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain: %0d checks left, expected 0", sb.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
